// File: rtl/dcmac_reset_sequencer.sv
// -----------------------------------------------------------------------------
// dcmac_reset_sequencer
//
// Initiator side of the GT reset handshake for the dual-port 100GbE DCMAC.
// Issues the power-on full GT reset, per-port RX datapath resets on request,
// watches the (already synchronized) reset-done status with a timeout,
// retries the full sequence a bounded number of times and parks in FAIL.
//
// Ports
//   s_axi_clk                  in   sole clock
//   resetn                     in   synchronous active-low reset
//   start                      in   pulse: full GT reset, clear retries/error
//   rx_reset_req[1:0]          in   per-port pulse: RX datapath reset request
//   gt_tx_reset_done[1:0]      in   per-port TX reset done (s_axi_clk domain)
//   gt_rx_reset_done[1:0]      in   per-port RX reset done (s_axi_clk domain)
//   user_gt_reset_all          out  full GT reset request
//   user_gt_reset_rx_datapath  out  per-port RX datapath reset request
//   busy                       out  sequence in progress
//   ready                      out  both ports up, idling in READY
//   error                      out  sticky failure flag
//   retry_count[3:0]           out  full-sequence retries since start/reset
//   state[2:0]                 out  FSM state for debug
//
// All outputs come straight from flops; next-state logic is in one
// always_comb and every register (state and outputs) in one always_ff.
// -----------------------------------------------------------------------------
module dcmac_reset_sequencer #(
    parameter int RESET_CYCLES   = 100,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int MAX_RETRIES    = 3,
    parameter bit AUTO_START     = 1'b1
) (
    input  logic       s_axi_clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] rx_reset_req,
    input  logic [1:0] gt_tx_reset_done,
    input  logic [1:0] gt_rx_reset_done,
    output logic       user_gt_reset_all,
    output logic [1:0] user_gt_reset_rx_datapath,
    output logic       busy,
    output logic       ready,
    output logic       error,
    output logic [3:0] retry_count,
    output logic [2:0] state
);

    localparam int HOLD_W = $clog2(RESET_CYCLES) + 1;
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_ASSERT_ALL   = 3'd1,
        S_WAIT_TX      = 3'd2,
        S_WAIT_RX      = 3'd3,
        S_READY        = 3'd4,
        S_RX_RESET     = 3'd5,
        S_WAIT_RX_PORT = 3'd6,
        S_FAIL         = 3'd7
    } state_e;

    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [3:0]        retry_q, retry_d;
    logic              error_q, error_d;
    logic [1:0]        seen_tx_q, seen_tx_d;
    logic [1:0]        seen_rx_q, seen_rx_d;
    logic [1:0]        pmask_q, pmask_d;

    logic              rst_all_q;
    logic [1:0]        rst_rx_q;
    logic              busy_q;
    logic              ready_q;

    logic [1:0]        qual_tx, qual_rx;
    logic              tmo_hit;
    logic              go_all;

    // A done bit only counts once it has been seen low since the reset was
    // issued; a done left high from before the reset is ignored.
    assign qual_tx = gt_tx_reset_done & seen_tx_q;
    assign qual_rx = gt_rx_reset_done & seen_rx_q;
    assign tmo_hit = (tmo_q == TMO_LAST);

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        tmo_d     = tmo_q;
        retry_d   = retry_q;
        error_d   = error_q;
        seen_tx_d = seen_tx_q;
        seen_rx_d = seen_rx_q;
        pmask_d   = pmask_q;
        go_all    = 1'b0;

        // seen_low tracking windows
        if (state_q == S_ASSERT_ALL || state_q == S_WAIT_TX || state_q == S_WAIT_RX) begin
            seen_tx_d = seen_tx_q | ~gt_tx_reset_done;
            seen_rx_d = seen_rx_q | ~gt_rx_reset_done;
        end else if (state_q == S_RX_RESET || state_q == S_WAIT_RX_PORT) begin
            seen_rx_d = seen_rx_q | ~gt_rx_reset_done;
        end

        case (state_q)
            S_IDLE: begin
                if (AUTO_START) go_all = 1'b1;
            end

            S_ASSERT_ALL, S_RX_RESET: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = (state_q == S_ASSERT_ALL) ? S_WAIT_TX : S_WAIT_RX_PORT;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end

            S_WAIT_TX, S_WAIT_RX, S_WAIT_RX_PORT: begin
                // Qualification wins over a timeout sampled on the same edge.
                if (state_q == S_WAIT_TX && (&qual_tx)) begin
                    state_d = S_WAIT_RX;
                    tmo_d   = tmo_q + TMO_W'(1);
                end else if (state_q == S_WAIT_RX && (&qual_rx)) begin
                    state_d = S_READY;
                end else if (state_q == S_WAIT_RX_PORT && ((qual_rx & pmask_q) == pmask_q)) begin
                    state_d = S_READY;
                end else if (tmo_hit) begin
                    // A port-level timeout escalates to a full retry as well.
                    if (int'(retry_q) < MAX_RETRIES) begin
                        retry_d = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
                        go_all  = 1'b1;
                    end else begin
                        state_d = S_FAIL;
                        error_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_READY: begin
                if (rx_reset_req != 2'b00) begin
                    pmask_d   = rx_reset_req;
                    state_d   = S_RX_RESET;
                    hold_d    = '0;
                    tmo_d     = '0;
                    seen_rx_d = 2'b00;
                end
            end

            default: ; // S_FAIL: wait for start
        endcase

        // start overrides anything decided above, including a pending
        // rx_reset_req in READY and a running hold count.
        if (start) begin
            retry_d = 4'd0;
            error_d = 1'b0;
            go_all  = 1'b1;
        end

        if (go_all) begin
            state_d   = S_ASSERT_ALL;
            hold_d    = '0;
            tmo_d     = '0;
            seen_tx_d = 2'b00;
            seen_rx_d = 2'b00;
        end
    end

    always_ff @(posedge s_axi_clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            hold_q    <= '0;
            tmo_q     <= '0;
            retry_q   <= 4'd0;
            error_q   <= 1'b0;
            seen_tx_q <= 2'b00;
            seen_rx_q <= 2'b00;
            pmask_q   <= 2'b00;
            rst_all_q <= 1'b0;
            rst_rx_q  <= 2'b00;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            tmo_q     <= tmo_d;
            retry_q   <= retry_d;
            error_q   <= error_d;
            seen_tx_q <= seen_tx_d;
            seen_rx_q <= seen_rx_d;
            pmask_q   <= pmask_d;
            // Outputs are decoded from the next state so they line up with
            // state_q in the same cycle while still being flop outputs.
            rst_all_q <= (state_d == S_ASSERT_ALL);
            rst_rx_q  <= (state_d == S_RX_RESET) ? pmask_d : 2'b00;
            busy_q    <= !(state_d == S_IDLE || state_d == S_READY || state_d == S_FAIL);
            ready_q   <= (state_d == S_READY);
        end
    end

    assign user_gt_reset_all         = rst_all_q;
    assign user_gt_reset_rx_datapath = rst_rx_q;
    assign busy                      = busy_q;
    assign ready                     = ready_q;
    assign error                     = error_q;
    assign retry_count               = retry_q;
    assign state                     = state_q;

endmodule

// File: tb/tb_dcmac_reset_sequencer.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for dcmac_reset_sequencer.
// RESET_CYCLES=4, TIMEOUT_CYCLES=20, MAX_RETRIES=2, AUTO_START=1.
// Inputs change #1 after a rising edge; outputs are checked at the same point.
// A timeout is taken on the 21st wait-state edge (counter 0..20, fires at 20),
// so from the edge entering a hold state the retry edge is 4+21 = 25 edges on.
// -----------------------------------------------------------------------------
module tb_dcmac_reset_sequencer;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic [1:0] rx_reset_req;
    logic [1:0] tx_done;
    logic [1:0] rx_done;
    logic       user_gt_reset_all;
    logic [1:0] user_gt_reset_rx_datapath;
    logic       busy;
    logic       ready;
    logic       error;
    logic [3:0] retry_count;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;
    int all_hi = 0;
    int rx0_hi = 0;
    int rx1_hi = 0;

    dcmac_reset_sequencer #(
        .RESET_CYCLES  (4),
        .TIMEOUT_CYCLES(20),
        .MAX_RETRIES   (2),
        .AUTO_START    (1'b1)
    ) dut (
        .s_axi_clk                (clk),
        .resetn                   (resetn),
        .start                    (start),
        .rx_reset_req             (rx_reset_req),
        .gt_tx_reset_done         (tx_done),
        .gt_rx_reset_done         (rx_done),
        .user_gt_reset_all        (user_gt_reset_all),
        .user_gt_reset_rx_datapath(user_gt_reset_rx_datapath),
        .busy                     (busy),
        .ready                    (ready),
        .error                    (error),
        .retry_count              (retry_count),
        .state                    (state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // one clock, then tally reset-request high cycles
    task automatic step();
        @(posedge clk);
        #1;
        if (user_gt_reset_all)               all_hi++;
        if (user_gt_reset_rx_datapath[0])    rx0_hi++;
        if (user_gt_reset_rx_datapath[1])    rx1_hi++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_state(input string tag, input logic [2:0] s, input int max);
        for (int i = 0; i < max && state != s; i++) step();
        chk(tag, 32'(state), 32'(s));
    endtask

    task automatic clr_cnt();
        all_hi = 0;
        rx0_hi = 0;
        rx1_hi = 0;
    endtask

    initial begin
        resetn       = 1'b0;
        start        = 1'b0;
        rx_reset_req = 2'b00;
        tx_done      = 2'b00;
        rx_done      = 2'b00;
        steps(3);
        chk("reset_outs", 32'({user_gt_reset_all, user_gt_reset_rx_datapath, busy, ready,
                               error, retry_count, state}), 32'd0);

        // 1. power-on sequence
        clr_cnt();
        resetn = 1'b1;
        step();
        chk("po_assert_all", 32'(state), 32'd1);
        steps(5);
        chk("po_wait_tx", 32'(state), 32'd2);
        tx_done = 2'b11;
        step();
        chk("po_wait_rx", 32'(state), 32'd3);
        steps(2);
        rx_done = 2'b11;
        chk("po_ready_early", 32'(ready), 32'd0);
        step();
        chk("po_ready", 32'(ready), 32'd1);
        chk("po_all_hi", 32'(all_hi), 32'd4);
        chk("po_retry", 32'(retry_count), 32'd0);
        chk("po_busy", 32'(busy), 32'd0);

        // 2. stale done held high: three timeouts then FAIL
        clr_cnt();
        start = 1'b1;
        step();
        start = 1'b0;
        chk("st_start", 32'(state), 32'd1);
        steps(24);
        chk("st_pre_tmo", {28'd0, retry_count}, 32'd0);
        chk("st_pre_state", 32'(state), 32'd2);
        step();
        chk("st_retry1", {28'd0, retry_count}, 32'd1);
        chk("st_retry1_st", 32'(state), 32'd1);
        steps(25);
        chk("st_retry2", {28'd0, retry_count}, 32'd2);
        steps(25);
        chk("st_fail_state", 32'(state), 32'd7);
        chk("st_error", 32'(error), 32'd1);
        chk("st_retry_fin", {28'd0, retry_count}, 32'd2);
        chk("st_fail_outs", 32'({user_gt_reset_all, user_gt_reset_rx_datapath, busy}), 32'd0);
        chk("st_all_hi", 32'(all_hi), 32'd12);

        // 3. first attempt never completes, second one does
        tx_done = 2'b00;
        rx_done = 2'b00;
        start   = 1'b1;
        step();
        start   = 1'b0;
        chk("rr_err_clr", 32'(error), 32'd0);
        chk("rr_retry_clr", {28'd0, retry_count}, 32'd0);
        steps(25);
        chk("rr_retry1", {28'd0, retry_count}, 32'd1);
        steps(2);
        tx_done = 2'b11;
        rx_done = 2'b11;
        wait_state("rr_ready_st", 3'd4, 40);
        chk("rr_ready", 32'(ready), 32'd1);
        chk("rr_retry_fin", {28'd0, retry_count}, 32'd1);

        // 4. per-port RX reset on port 1 only
        clr_cnt();
        rx_reset_req = 2'b10;
        step();
        rx_reset_req = 2'b00;
        chk("pp_state", 32'(state), 32'd5);
        chk("pp_mask", 32'(user_gt_reset_rx_datapath), 32'd2);
        rx_done = 2'b01;
        steps(5);
        rx_done = 2'b11;
        wait_state("pp_back_ready", 3'd4, 30);
        chk("pp_rx1_hi", 32'(rx1_hi), 32'd4);
        chk("pp_rx0_hi", 32'(rx0_hi), 32'd0);
        chk("pp_all_hi", 32'(all_hi), 32'd0);

        // 5. port 0 RX reset that never completes escalates to a full retry
        rx_reset_req = 2'b01;
        rx_done      = 2'b10;
        step();
        rx_reset_req = 2'b00;
        chk("pt_state", 32'(state), 32'd5);
        steps(24);
        chk("pt_wait", 32'(state), 32'd6);
        step();
        chk("pt_escalate", 32'(state), 32'd1);
        chk("pt_retry", {28'd0, retry_count}, 32'd2);
        chk("pt_all", 32'(user_gt_reset_all), 32'd1);
        tx_done = 2'b00;
        rx_done = 2'b00;
        step();
        tx_done = 2'b11;
        rx_done = 2'b11;
        wait_state("pt_recover", 3'd4, 40);

        // 6a. start beats rx_reset_req in READY
        start        = 1'b1;
        rx_reset_req = 2'b11;
        step();
        start        = 1'b0;
        rx_reset_req = 2'b00;
        chk("pr_state", 32'(state), 32'd1);
        chk("pr_retry", {28'd0, retry_count}, 32'd0);
        chk("pr_rxdp", 32'(user_gt_reset_rx_datapath), 32'd0);

        // 6b. resetn mid-WAIT_RX
        tx_done = 2'b00;
        rx_done = 2'b00;
        step();
        tx_done = 2'b11;
        wait_state("pr_wait_rx", 3'd3, 20);
        chk("pr_busy_pre", 32'(busy), 32'd1);
        resetn = 1'b0;
        step();
        chk("pr_rst_outs", 32'({user_gt_reset_all, user_gt_reset_rx_datapath, busy, ready,
                                error, retry_count, state}), 32'd0);
        resetn = 1'b1;
        step();
        chk("pr_autostart", 32'(state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
